// File: rtl/pc_redirect_ctrl_if.sv
// rtl/pc_redirect_ctrl_if.sv - fetch redirect control signal bundle
interface pc_redirect_ctrl_if;
    logic        stallF;
    logic        flush_excp;
    logic [31:0] excp_pc;
    logic        branchD;
    logic        takenD;
    logic [31:0] targetD;
    logic [31:0] pcF;
    logic [31:0] pc_plus4F;
    logic        in_delayslotF;
    logic        adelF;
    logic        redirect_pend;

    modport master (
        output stallF, flush_excp, excp_pc, branchD, takenD, targetD,
        input  pcF, pc_plus4F, in_delayslotF, adelF, redirect_pend
    );

    modport slave (
        input  stallF, flush_excp, excp_pc, branchD, takenD, targetD,
        output pcF, pc_plus4F, in_delayslotF, adelF, redirect_pend
    );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - fetch PC register with stall-safe branch/exception redirect
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'hBFC0_0000,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic                clk,
    input  logic                resetn,
    pc_redirect_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_PEND = 2'd1,
        EX_PEND = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] pc_plus4;
    logic        br_taken;

    assign pc_plus4 = pc_q + 32'd4;
    assign br_taken = bus.branchD & bus.takenD;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        case (state_q)
            RUN: begin
                if (!bus.stallF) begin
                    pc_d = bus.flush_excp ? bus.excp_pc
                         : br_taken       ? bus.targetD
                         :                  pc_plus4;
                end else if (bus.flush_excp) begin
                    pend_pc_d = bus.excp_pc;
                    state_d   = EX_PEND;
                end else if (br_taken) begin
                    pend_pc_d = bus.targetD;
                    state_d   = BR_PEND;
                end
            end
            // Decode repeats the held branch while stalled, so only an exception may replace it.
            BR_PEND, EX_PEND: begin
                if (bus.stallF) begin
                    if (bus.flush_excp) begin
                        pend_pc_d = bus.excp_pc;
                        state_d   = EX_PEND;
                    end
                end else begin
                    pc_d    = bus.flush_excp ? bus.excp_pc : pend_pc_q;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            pend_pc_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign bus.pcF           = pc_q;
    assign bus.pc_plus4F     = pc_plus4;
    assign bus.redirect_pend = (state_q != RUN);
    assign bus.in_delayslotF = bus.branchD & (state_q == RUN);
    assign bus.adelF         = ALIGN_CHECK && (pc_q[1:0] != 2'b00);
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - directed self-checking bench for pc_redirect_ctrl
module tb_pc_redirect_ctrl;
    logic clk;
    logic resetn;
    int   n_cmp;
    int   n_err;

    pc_redirect_ctrl_if bus ();

    pc_redirect_ctrl #(
        .RESET_PC    (32'hBFC0_0000),
        .ALIGN_CHECK (1'b1)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic stall, input logic flush, input logic [31:0] epc,
                         input logic br, input logic tk, input logic [31:0] tgt);
        bus.stallF     = stall;
        bus.flush_excp = flush;
        bus.excp_pc    = epc;
        bus.branchD    = br;
        bus.takenD     = tk;
        bus.targetD    = tgt;
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        resetn = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        step();
        check("rst_pc",     bus.pcF,           32'hBFC0_0000);
        check("rst_plus4",  bus.pc_plus4F,     32'hBFC0_0004);
        check("rst_pend",   bus.redirect_pend, 32'd0);
        check("rst_adel",   bus.adelF,         32'd0);
        resetn = 1'b1;

        // free run
        step(); check("run1", bus.pcF, 32'hBFC0_0004);
        step(); check("run2", bus.pcF, 32'hBFC0_0008);
        step(); check("run3", bus.pcF, 32'hBFC0_000C);
        check("run_pend", bus.redirect_pend, 32'd0);

        // taken branch, no stall
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hBFC0_0100);
        check("ds_flag", bus.in_delayslotF, 32'd1);
        step(); check("br_pc", bus.pcF, 32'hBFC0_0100);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("ds_clear", bus.in_delayslotF, 32'd0);
        step(); check("br_seq", bus.pcF, 32'hBFC0_0104);

        // branch held during a 3-cycle stall
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0400);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc",   bus.pcF,           32'hBFC0_0104);
            check("stall_pend", bus.redirect_pend, 32'd1);
            check("stall_ds",   bus.in_delayslotF, 32'd0);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0400);
        step();
        check("rel_pc",   bus.pcF,           32'h0000_0400);
        check("rel_pend", bus.redirect_pend, 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(); check("rel_seq", bus.pcF, 32'h0000_0404);

        // held branch overtaken by exception, later branch ignored
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0400);
        step(); check("bp_pend", bus.redirect_pend, 32'd1);
        drive(1'b1, 1'b1, 32'hBFC0_0380, 1'b1, 1'b1, 32'h0000_0400);
        step(); check("ex_pc", bus.pcF, 32'h0000_0404);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0800);
        check("ex_ds", bus.in_delayslotF, 32'd0);
        step(); check("ex_pend", bus.redirect_pend, 32'd1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(); check("ex_rel", bus.pcF, 32'hBFC0_0380);
        step(); check("ex_seq", bus.pcF, 32'hBFC0_0384);

        // second exception while held replaces the first
        drive(1'b1, 1'b1, 32'hBFC0_0380, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b1, 1'b1, 32'hBFC0_0200, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(); check("ex_over", bus.pcF, 32'hBFC0_0200);

        // concurrent flush and taken branch, no stall
        drive(1'b0, 1'b1, 32'hBFC0_0380, 1'b1, 1'b1, 32'h0000_0400);
        step(); check("conc_pc", bus.pcF, 32'hBFC0_0380);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(); check("conc_seq", bus.pcF, 32'hBFC0_0384);

        // misaligned target
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0402);
        step();
        check("mis_pc",   bus.pcF,   32'h0000_0402);
        check("mis_adel", bus.adelF, 32'd1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        check("mis_seq",   bus.pcF,   32'h0000_0406);
        check("mis_adel2", bus.adelF, 32'd1);

        // wrap at top of address space
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        step();
        check("wrap_pc",    bus.pcF,       32'hFFFF_FFFC);
        check("wrap_plus4", bus.pc_plus4F, 32'h0000_0000);
        check("wrap_adel",  bus.adelF,     32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(); check("wrap_next", bus.pcF, 32'h0000_0000);

        // async reset while a redirect is held
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0500);
        step(); check("mr_pend", bus.redirect_pend, 32'd1);
        resetn = 1'b0;
        #1;
        check("mr_pc",    bus.pcF,           32'hBFC0_0000);
        check("mr_clear", bus.redirect_pend, 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        resetn = 1'b1;
        step(); check("mr_after", bus.pcF, 32'hBFC0_0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
